reload_timer: RTL and testbench

Parametrised down-counting timer with auto-reload, programmable prescaler and one-shot/periodic modes. It generalises the fixed 32-bit preset/enable/zero timer used in the sensor-node SoC cell library, and it adds expiry pulses, run/done status and a readable count. It sits beside the ISM and bus peripherals and generates wake-up and sampling ticks.

---
 rtl/reload_timer.sv | 131 +++++++++++++
 tb/tb_reload_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reload_timer.sv
// reload_timer: down-counting timer with programmable prescaler, auto-reload and
// one-shot/periodic modes. It signals expiry with a registered one-cycle pulse.
module reload_timer #(
  parameter int Width          = 32,
  parameter int PrescalerWidth = 8
) (
  input  logic                      Clk_i,
  input  logic                      Reset_n_i,
  input  logic                      Preset_i,
  input  logic                      Enable_i,
  input  logic                      Mode_i,
  input  logic [Width-1:0]          PresetVal_i,
  input  logic [PrescalerWidth-1:0] Prescale_i,
  output logic [Width-1:0]          Value_o,
  output logic                      Zero_o,
  output logic                      Expired_o,
  output logic                      Running_o,
  output logic                      Done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [Width-1:0]          ValZero = {Width{1'b0}};
  localparam logic [Width-1:0]          ValOne  = {{(Width-1){1'b0}}, 1'b1};
  localparam logic [PrescalerWidth-1:0] PreZero = {PrescalerWidth{1'b0}};
  localparam logic [PrescalerWidth-1:0] PreOne  = {{(PrescalerWidth-1){1'b0}}, 1'b1};

  state_e                      state_q,   state_d;
  logic [Width-1:0]            value_q,   value_d;
  logic [Width-1:0]            reload_q,  reload_d;
  logic [PrescalerWidth-1:0]   precnt_q,  precnt_d;
  logic                        expired_q, expired_d;
  logic                        tick_s;

  // A tick is due once the prescaler count reaches the compare value; >= absorbs a
  // compare value lowered while the count is already past it.
  always_comb begin
    tick_s = 1'b0;
    if ((state_q == ST_RUN) && Enable_i && (precnt_q >= Prescale_i)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Next-state: preset dominates counting; IDLE and DONE only leave via preset.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    reload_d  = reload_q;
    precnt_d  = precnt_q;
    expired_d = 1'b0;
    if (Preset_i) begin
      value_d  = PresetVal_i;
      reload_d = PresetVal_i;
      precnt_d = PreZero;
      if (PresetVal_i != ValZero) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!Enable_i) begin
            precnt_d = precnt_q;
          end else if (!tick_s) begin
            precnt_d = precnt_q + PreOne;
          end else begin
            precnt_d = PreZero;
            if (value_q > ValOne) begin
              value_d = value_q - ValOne;
            end else if (value_q == ValOne) begin
              expired_d = 1'b1;
              if (Mode_i) begin
                value_d = reload_q;
              end else begin
                value_d = ValZero;
                state_d = ST_DONE;
              end
            end else begin
              // Unreachable in normal use; never step below zero.
              value_d = ValZero;
              state_d = ST_DONE;
            end
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d  = ST_IDLE;
          value_d  = ValZero;
          reload_d = ValZero;
          precnt_d = PreZero;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      state_q   <= ST_IDLE;
      value_q   <= ValZero;
      reload_q  <= ValZero;
      precnt_q  <= PreZero;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      precnt_q  <= precnt_d;
      expired_q <= expired_d;
    end
  end

  assign Value_o   = value_q;
  assign Zero_o    = (value_q == ValZero);
  assign Expired_o = expired_q;
  assign Running_o = (state_q == ST_RUN);
  assign Done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_reload_timer.sv
// Testbench for reload_timer: directed test-plan steps plus randomized traffic checked
// against an arithmetic model (value = reload - enabled_cycles / (prescale + 1)).
module tb_reload_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preset = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] pval = 32'd0;
  logic [7:0]  pscale = 8'd0;
  logic [31:0] value;
  logic        zero, expired, running, done;

  logic        w8_preset = 1'b0;
  logic        w8_enable = 1'b0;
  logic        w8_mode = 1'b0;
  logic [7:0]  w8_pval = 8'd0;
  logic [1:0]  w8_pscale = 2'd0;
  logic [7:0]  w8_value;
  logic        w8_zero, w8_expired, w8_running, w8_done;

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 run, 2 done; m_cnt counts enabled RUN cycles since the last (re)load.
  int     m_st = 0;
  longint m_val = 0, m_rel = 0, m_cnt = 0, m_ps = 0;
  bit     m_exp = 1'b0;

  always #5 clk = ~clk;

  reload_timer #(.Width(32), .PrescalerWidth(8)) dut (
    .Clk_i(clk), .Reset_n_i(rst_n), .Preset_i(preset), .Enable_i(enable), .Mode_i(mode),
    .PresetVal_i(pval), .Prescale_i(pscale), .Value_o(value), .Zero_o(zero),
    .Expired_o(expired), .Running_o(running), .Done_o(done)
  );

  reload_timer #(.Width(8), .PrescalerWidth(2)) dut_w8 (
    .Clk_i(clk), .Reset_n_i(rst_n), .Preset_i(w8_preset), .Enable_i(w8_enable), .Mode_i(w8_mode),
    .PresetVal_i(w8_pval), .Prescale_i(w8_pscale), .Value_o(w8_value), .Zero_o(w8_zero),
    .Expired_o(w8_expired), .Running_o(w8_running), .Done_o(w8_done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rn, input bit pre, input bit en, input bit md,
                            input longint pv, input longint ps);
    m_exp = 1'b0;
    if (!rn) begin
      m_st = 0; m_val = 0; m_rel = 0; m_cnt = 0;
    end else if (pre) begin
      m_val = pv; m_rel = pv; m_cnt = 0; m_ps = ps;
      m_st = (pv != 0) ? 1 : 0;
    end else if (m_st == 1 && en) begin
      m_cnt++;
      if (m_cnt == m_rel * (m_ps + 1)) begin
        m_exp = 1'b1;
        m_cnt = 0;
        if (md) m_val = m_rel;
        else begin
          m_val = 0;
          m_st = 2;
        end
      end else begin
        m_val = m_rel - m_cnt / (m_ps + 1);
      end
    end
  endtask

  task automatic cyc(input bit rn, input bit pre, input bit en, input bit md,
                     input logic [31:0] pv, input logic [7:0] ps);
    rst_n = rn; preset = pre; enable = en; mode = md; pval = pv; pscale = ps;
    @(posedge clk);
    model_edge(rn, pre, en, md, longint'(pv), longint'(ps));
    #1;
    chk("value", longint'(value), m_val);
    chk("zero", longint'(zero), longint'(m_val == 0));
    chk("expired", longint'(expired), longint'(m_exp));
    chk("running", longint'(running), longint'(m_st == 1));
    chk("done", longint'(done), longint'(m_st == 2));
  endtask

  initial begin
    int pulses, zeros, hit;
    bit r_pre, r_en, r_md, r_rn;
    logic [31:0] r_pv;
    logic [7:0]  r_ps;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    chk("reset_zero", longint'(zero), 1);
    chk("reset_value", longint'(value), 0);

    // Reset mid-run overrides a simultaneous preset
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 8'd0);
    chk("midrun_value", longint'(value), 7);
    chk("midrun_running", longint'(running), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd7, 8'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd7, 8'd0);
    chk("rst_value", longint'(value), 0);
    chk("rst_running", longint'(running), 0);

    // One-shot P=5 S=0
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 8'd0);
    pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0);
      if (i <= 5) chk("os_value_seq", longint'(value), longint'(5 - i));
      if (expired) begin
        pulses++;
        chk("os_pulse_at", i, 5);
      end
    end
    chk("os_pulses", pulses, 1);
    chk("os_done_sticky", longint'(done), 1);
    chk("os_zero_sticky", longint'(zero), 1);

    // Periodic P=3 S=1: pulse every 6 cycles, Zero_o never asserted
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 8'd1);
    pulses = 0; zeros = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 8'd1);
      if (expired) pulses++;
      if (zero) zeros++;
      if (i == 6) chk("per_reload_value", longint'(value), 3);
    end
    chk("per_pulses", pulses, 4);
    chk("per_zero_count", zeros, 0);

    // Enable gap of 5 cycles: expiry 12+5 edges after the preset
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 8'd2);
    hit = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc(1'b1, 1'b0, !(i >= 4 && i <= 8), 1'b0, 32'd0, 8'd2);
      if (expired && hit == 0) hit = i;
    end
    chk("gap_expiry_edge", hit, 17);

    // Preset on the expiry edge wins
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 8'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd9, 8'd0);
    chk("coll_expired", longint'(expired), 0);
    chk("coll_value", longint'(value), 9);
    chk("coll_running", longint'(running), 1);

    // Preset zero goes to IDLE; enable has no effect
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    chk("p0_running", longint'(running), 0);
    chk("p0_zero", longint'(zero), 1);
    chk("p0_done", longint'(done), 0);

    // Narrow instance: P=255, S=3 one-shot expires 1020 edges after preset
    w8_pval = 8'hFF; w8_pscale = 2'd3; w8_mode = 1'b0; w8_preset = 1'b1; w8_enable = 1'b1;
    @(posedge clk); #1;
    w8_preset = 1'b0;
    chk("w8_preset_value", longint'(w8_value), 255);
    hit = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      if (w8_expired) begin
        hit = i;
        break;
      end
    end
    chk("w8_expiry_edge", hit, 1020);
    chk("w8_value_end", longint'(w8_value), 0);
    chk("w8_done", longint'(w8_done), 1);
    w8_enable = 1'b0;

    // Randomized traffic; prescale only changes together with a preset
    r_ps = 8'd0;
    for (int i = 0; i < 600; i++) begin
      r_rn  = ($urandom_range(0, 99) != 0);
      r_pre = ($urandom_range(0, 11) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_md  = $urandom_range(0, 1);
      r_pv  = 32'($urandom_range(0, 6));
      if (r_pre) r_ps = 8'($urandom_range(0, 3));
      cyc(r_rn, r_pre, r_en, r_md, r_pv, r_ps);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
